// File: rtl/game_mode_ctrl.sv
// Game-flow sequencer: title/play/pause/over modes, life counting from per-frame
// collision samples, hit immunity and game-over hold timers in frame units.
module game_mode_ctrl #(
  parameter int MAX_HEART        = 5,
  parameter int INVULN_FRAMES    = 60,
  parameter int OVER_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       collision,
  output logic [1:0] gamemode,
  output logic [2:0] heart,
  output logic       invuln,
  output logic       player_blank,
  output logic       round_reset
);

  // state    | meaning
  // S_INIT   | title screen, waiting for start
  // S_PLAY   | round running, lives and immunity active
  // S_PAUSE  | round frozen, only pause resumes
  // S_OVER   | out of lives, start accepted once hold timer expires
  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  // inv_cnt keeps at least 3 bits so the blink tap on bit 2 always exists
  localparam int INV_RAW  = $clog2(INVULN_FRAMES + 1);
  localparam int INV_W    = (INV_RAW < 3) ? 3 : INV_RAW;
  localparam int HOLD_RAW = $clog2(OVER_HOLD_FRAMES + 1);
  localparam int HOLD_W   = (HOLD_RAW < 1) ? 1 : HOLD_RAW;

  localparam logic [INV_W-1:0]  INV_LOAD  = INV_W'(INVULN_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVER_HOLD_FRAMES);
  localparam logic [2:0]        HEART_MAX = 3'(MAX_HEART);

  state_t            state;
  logic [INV_W-1:0]  inv_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_q;
  logic              pause_q;
  logic              start_rise;
  logic              pause_rise;
  logic              hit;
  logic              fatal_hit;

  assign start_rise = btn_start & ~start_q;
  assign pause_rise = btn_pause & ~pause_q;
  assign hit        = frame_tick && (inv_cnt == '0) && collision;
  assign fatal_hit  = hit && (heart == 3'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      heart       <= HEART_MAX;
      inv_cnt     <= '0;
      hold_cnt    <= '0;
      start_q     <= 1'b1;
      pause_q     <= 1'b1;
      round_reset <= 1'b0;
    end else begin
      start_q     <= btn_start;
      pause_q     <= btn_pause;
      round_reset <= 1'b0;
      case (state)
        S_INIT: begin
          heart   <= HEART_MAX;
          inv_cnt <= '0;
          if (start_rise) begin
            state       <= S_PLAY;
            round_reset <= 1'b1;
            inv_cnt     <= INV_LOAD;
          end
        end
        S_PLAY: begin
          if (frame_tick && (inv_cnt != '0)) begin
            inv_cnt <= inv_cnt - INV_W'(1);
          end else if (hit) begin
            heart <= heart - 3'd1;
            if (fatal_hit) begin
              state    <= S_OVER;
              hold_cnt <= HOLD_LOAD;
            end else begin
              inv_cnt <= INV_LOAD;
            end
          end
          // a fatal hit in the same cycle outranks the pause request
          if (pause_rise && !fatal_hit) state <= S_PAUSE;
        end
        S_PAUSE: begin
          if (pause_rise) state <= S_PLAY;
        end
        S_OVER: begin
          heart <= 3'd0;
          if (start_rise && (hold_cnt == '0)) begin
            state <= S_INIT;
            heart <= HEART_MAX;
          end else if (frame_tick && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign gamemode     = state;
  assign invuln       = ((state == S_PLAY) || (state == S_PAUSE)) && (inv_cnt != '0);
  assign player_blank = invuln & inv_cnt[2];

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: vector table, directed round sequences, and a
// randomized run checked against a behavioural game model.
module tb_game_mode_ctrl;

  localparam int MAXH = 5;
  localparam int INV  = 60;
  localparam int HOLD = 120;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] gamemode;
  logic [2:0] heart;
  logic       invuln;
  logic       player_blank;
  logic       round_reset;

  int n_chk  = 0;
  int n_pass = 0;

  game_mode_ctrl #(.MAX_HEART(MAXH), .INVULN_FRAMES(INV), .OVER_HOLD_FRAMES(HOLD)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .btn_start(btn_start),
    .btn_pause(btn_pause), .collision(collision), .gamemode(gamemode),
    .heart(heart), .invuln(invuln), .player_blank(player_blank),
    .round_reset(round_reset)
  );

  always #5 clk = ~clk;

  // behavioural model: mode 0 title, 1 play, 2 pause, 3 over
  int m_mode = 0, m_lives = MAXH, m_imm = 0, m_hold = 0, m_rr = 0;
  bit m_sprev = 1'b1, m_pprev = 1'b1;

  task automatic model_step();
    bit s, p;
    int old_hold;
    if (rst) begin
      m_mode = 0; m_lives = MAXH; m_imm = 0; m_hold = 0; m_rr = 0;
      m_sprev = 1'b1; m_pprev = 1'b1;
      return;
    end
    s = btn_start && !m_sprev;
    p = btn_pause && !m_pprev;
    m_rr = 0;
    if (m_mode == 0) begin
      m_lives = MAXH; m_imm = 0;
      if (s) begin m_mode = 1; m_rr = 1; m_imm = INV; end
    end else if (m_mode == 1) begin
      if (frame_tick) begin
        if (m_imm > 0) m_imm = m_imm - 1;
        else if (collision) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) begin m_mode = 3; m_hold = HOLD; end
          else m_imm = INV;
        end
      end
      if (p && m_mode == 1) m_mode = 2;
    end else if (m_mode == 2) begin
      if (p) m_mode = 1;
    end else begin
      old_hold = m_hold;
      if (frame_tick && m_hold > 0) m_hold = m_hold - 1;
      if (s && old_hold == 0) begin m_mode = 0; m_lives = MAXH; end
    end
    m_sprev = btn_start;
    m_pprev = btn_pause;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    else n_pass++;
  endtask

  task automatic cyc(input bit r, input bit t, input bit s, input bit p, input bit c);
    rst = r; frame_tick = t; btn_start = s; btn_pause = p; collision = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // one frame: tick cycle then a quiet cycle, collision held throughout
  task automatic frame(input bit c, input bit p);
    cyc(0, 1, 0, p, c);
    cyc(0, 0, 0, 0, c);
  endtask

  typedef struct {
    bit r, t, s, p, c;
    int mode, hrt, inv, rr;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 0, 1, 0, 0, 0, 5, 0, 0};  // reset with start held
    vecs[1]  = '{0, 0, 1, 0, 0, 0, 5, 0, 0};  // still held: no event
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 5, 0, 0};
    vecs[3]  = '{0, 0, 1, 0, 0, 1, 5, 1, 1};  // press: round starts
    vecs[4]  = '{0, 0, 1, 0, 0, 1, 5, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 2, 5, 1, 0};  // pause
    vecs[6]  = '{0, 0, 0, 1, 0, 2, 5, 1, 0};
    vecs[7]  = '{0, 1, 0, 0, 1, 2, 5, 1, 0};  // tick ignored in pause
    vecs[8]  = '{0, 0, 0, 1, 0, 1, 5, 1, 0};  // resume
    vecs[9]  = '{0, 0, 1, 0, 0, 1, 5, 1, 0};  // start ignored in play
    vecs[10] = '{1, 0, 1, 0, 0, 0, 5, 0, 0};  // reset mid-round

    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].r, vecs[i].t, vecs[i].s, vecs[i].p, vecs[i].c);
      chk($sformatf("vec%0d_mode", i), gamemode, vecs[i].mode);
      chk($sformatf("vec%0d_heart", i), heart, vecs[i].hrt);
      chk($sformatf("vec%0d_invuln", i), invuln, vecs[i].inv);
      chk($sformatf("vec%0d_rr", i), round_reset, vecs[i].rr);
    end

    // constant collision, with a pause in the middle of an immunity window
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 1);
    chk("a_start_mode", gamemode, 1);
    cyc(0, 0, 0, 0, 1);
    for (int t = 1; t <= 70; t++) begin
      frame(1, 0);
      if (t == 60) chk("a_t60_heart", heart, 5);
      if (t == 61) begin chk("a_t61_heart", heart, 4); chk("a_t61_inv", invuln, 1); end
    end
    cyc(0, 0, 0, 1, 1);
    chk("b_pause_mode", gamemode, 2);
    cyc(0, 0, 0, 0, 1);
    for (int t = 0; t < 100; t++) frame(1, 0);
    chk("b_frozen_heart", heart, 4);
    chk("b_frozen_inv", invuln, 1);
    chk("b_frozen_mode", gamemode, 2);
    cyc(0, 0, 0, 1, 1);
    chk("b_resume_mode", gamemode, 1);
    cyc(0, 0, 0, 0, 1);
    for (int t = 71; t <= 304; t++) begin
      frame(1, 0);
      if (t == 121) chk("b_t121_heart", heart, 4);
      if (t == 122) chk("b_t122_heart", heart, 3);
      if (t == 304) begin chk("c_t304_heart", heart, 1); chk("c_t304_mode", gamemode, 1); end
    end
    // fatal hit coincident with pause press: over wins
    cyc(0, 1, 0, 1, 1);
    chk("c_fatal_mode", gamemode, 3);
    chk("c_fatal_heart", heart, 0);
    chk("c_fatal_inv", invuln, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0);
    chk("c_over_pause_ignored", gamemode, 3);
    cyc(0, 0, 0, 0, 0);

    // game-over hold
    for (int o = 1; o <= 121; o++) begin
      frame(0, 0);
      if (o == 50 || o == 119) begin
        cyc(0, 0, 1, 0, 0);
        chk($sformatf("d_early_start_o%0d", o), gamemode, 3);
        chk($sformatf("d_over_heart_o%0d", o), heart, 0);
        cyc(0, 0, 0, 0, 0);
      end
    end
    cyc(0, 0, 1, 0, 0);
    chk("d_init_mode", gamemode, 0);
    chk("d_init_heart", heart, 5);
    chk("d_init_rr", round_reset, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    chk("d_restart_mode", gamemode, 1);
    chk("d_restart_rr", round_reset, 1);
    cyc(0, 0, 0, 0, 0);
    chk("d_rr_one_cycle", round_reset, 0);

    // reset during pause with two lives left
    for (int t = 1; t <= 183; t++) frame(1, 0);
    chk("e_heart2", heart, 2);
    cyc(0, 0, 0, 1, 0);
    chk("e_pause_mode", gamemode, 2);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("e_rst_mode", gamemode, 0);
    chk("e_rst_heart", heart, 5);
    chk("e_rst_inv", invuln, 0);
    cyc(0, 0, 0, 0, 0);
    chk("e_idle_mode", gamemode, 0);

    // randomized run against the model
    begin
      bit ptick = 0, s = 0, p = 0;
      bit t, c, r;
      for (int i = 0; i < 8000; i++) begin
        r = ($urandom_range(0, 699) == 0);
        t = !ptick && ($urandom_range(0, 2) == 0);
        c = ($urandom_range(0, 9) < 7);
        if ($urandom_range(0, 5) == 0) s = ~s;
        if ($urandom_range(0, 149) == 0) p = ~p;
        cyc(r, t, s, p, c);
        ptick = t;
        chk("rand_mode", gamemode, m_mode);
        chk("rand_heart", heart, m_lives);
        chk("rand_invuln", invuln, int'(m_mode inside {1, 2} && m_imm > 0));
        chk("rand_blank", player_blank, int'(m_mode inside {1, 2} && m_imm > 0 && m_imm[2]));
        chk("rand_rr", round_reset, m_rr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
